pipe_addsub: RTL and testbench
==============================

PIPE_ADDSUB -- requirements
Module: pipe_addsub

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16: operand/result width in bits; legal values 4..64.
REQ-002 The block SHALL have parameter STAGES, default 4: pipeline depth; WIDTH SHALL be an integer multiple of STAGES.
REQ-003 The block SHALL have port clk, input, 1 bit: sole clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port in_valid, input, 1 bit: a, b and mode carry an operation.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the block can accept an operation this cycle.
REQ-007 The block SHALL have ports a and b, input, WIDTH bits each: operands.
REQ-008 The block SHALL have port mode, input, 1 bit: 0 = a+b, 1 = a-b.
REQ-009 The block SHALL have port out_valid, output, 1 bit: sum, cout and ovf hold a result.
REQ-010 The block SHALL have port out_ready, input, 1 bit: the consumer takes the result this cycle.
REQ-011 The block SHALL have port sum, output, WIDTH bits: result modulo 2^WIDTH.
REQ-012 The block SHALL have port cout, output, 1 bit: carry out of the MSB.
REQ-013 The block SHALL have port ovf, output, 1 bit: two's-complement signed overflow.

Function
REQ-014 Subtraction SHALL be computed as a + ~b + 1; cout SHALL be the raw carry (1 = no borrow, 0 = borrow).
REQ-015 ovf SHALL be 1 exactly when the effective operands (a and b, or a and ~b) share a sign bit and sum's MSB differs from it.
REQ-016 The datapath SHALL be split into STAGES chunks of WIDTH/STAGES bits; stage k adds chunk k using the carry registered from stage k-1; stage 0 takes carry-in = mode.
REQ-017 Not-yet-processed operand chunks and completed sum chunks SHALL travel in pipeline registers with the operation (skew/deskew), so the full sum emerges aligned.
REQ-018 An operation SHALL be accepted on a cycle with in_valid=1 and in_ready=1.
REQ-019 With out_ready held at 1, the result SHALL appear with out_valid=1 exactly STAGES cycles after acceptance.
REQ-020 Throughput SHALL be one operation per cycle when not stalled.
REQ-021 Pipeline advance enable SHALL be (out_ready or not out_valid); in_ready SHALL equal this enable, combinationally.
REQ-022 When enable=0, all stage registers, including each stage's valid bit, SHALL hold their values.
REQ-023 Bubbles SHALL propagate as valid=0 stages; when enable=1 a bubble SHALL be overwritten by the next stage's contents.
REQ-024 While out_valid=1 and out_ready=0, sum, cout and ovf SHALL remain stable.
REQ-025 Results SHALL leave in acceptance order, with no loss or duplication under any out_ready pattern.
REQ-026 Acceptance and retirement in the same cycle SHALL both take effect.
REQ-027 When in_valid=0 the contents of a, b and mode SHALL be ignored.

Reset
REQ-028 Asserting rst SHALL immediately clear every stage valid bit, so out_valid=0, independent of clk.
REQ-029 During reset, sum, cout and ovf SHALL be 0 and in_ready SHALL be 1.
REQ-030 Operations in flight when rst asserts SHALL be discarded, never emitted.
REQ-031 The first operation accepted after rst deasserts SHALL produce a correct result.

Structure
REQ-032 Package addsub_pkg SHALL hold MODE_ADD=1'b0, MODE_SUB=1'b1 and a shared stage-record layout (valid, remaining operand chunks, partial sum, carry).
REQ-033 Each stage's chunk adder SHALL be one sub-module, rca_chunk: combinational ripple-carry, parameter W, ports a, b, cin, sum, cout, plus the MSB carry-in for ovf.
REQ-034 Target implementation size SHALL be 120-400 lines of RTL.

Verification
REQ-035 Add scenario, WIDTH=16, STAGES=4: a=0x1234, b=0x4321, mode=0 -> sum=0x5555, cout=0, ovf=0, out_valid exactly 4 cycles after acceptance.
REQ-036 Subtract scenario: 0x0005-0x0007 -> sum=0xFFFE, cout=0, ovf=0; 0x0007-0x0005 -> sum=0x0002, cout=1, ovf=0.
REQ-037 Boundary scenario: 0x7FFF+0x0001 -> 0x8000, cout=0, ovf=1; 0xFFFF+0x0001 -> 0x0000, cout=1, ovf=0; 0x8000-0x0001 -> 0x7FFF, cout=1, ovf=1.
REQ-038 Backpressure scenario: stream 8 back-to-back operations, drop out_ready for 3 cycles mid-stream -> in_ready=0 during the stall, 8 correct results in order, outputs stable while stalled.
REQ-039 Reset scenario: assert rst with 3 operations in flight -> out_valid=0 at once, none of them emitted, next operation correct after STAGES cycles.
REQ-040 Random scenario: 10000 random a/b/mode vectors with random out_ready, at WIDTH=16/STAGES=4 and WIDTH=32/STAGES=8 -> zero mismatches against a reference model on sum, cout and ovf.

Source files
------------

// File: rtl/addsub_pkg.sv
// addsub_pkg: mode encodings and the per-stage control record for pipe_addsub.
package addsub_pkg;
  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;
  // Operand and partial-sum fields are WIDTH-dependent, so each stage keeps them beside this record
  typedef struct packed {
    logic valid;
    logic carry;
    logic ovf;
  } stage_ctl_t;
endpackage

// File: rtl/rca_chunk.sv
// rca_chunk: combinational ripple-carry adder slice, also exposing the carry into its MSB.
module rca_chunk #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         msb_cin
);
  logic [W:0] w_c;
  always_comb begin
    w_c = '0;
    sum = '0;
    w_c[0] = cin;
    for (int i = 0; i < W; i++) begin
      sum[i]    = a[i] ^ b[i] ^ w_c[i];
      w_c[i+1]  = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
    end
  end
  assign cout    = w_c[W];
  assign msb_cin = w_c[W-1];
endmodule

// File: rtl/pipe_addsub.sv
// pipe_addsub: STAGES-deep chunked add/subtract pipeline with valid/ready flow control.
module pipe_addsub
  import addsub_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int CW = WIDTH / STAGES;
  logic w_en;
  assign w_en     = out_ready | ~out_valid;
  assign in_ready = w_en;
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    stage_ctl_t       r_ctl;
    logic [WIDTH-1:0] r_a, r_b, r_s;
    logic             w_v, w_cin, w_co, w_cm;
    logic [WIDTH-1:0] w_a, w_b, w_s;
    logic [CW-1:0]    w_sum;
    if (k == 0) begin : g_head
      // Subtraction folds into the head: invert b once, carry-in supplies the +1
      assign w_v   = in_valid;
      assign w_cin = (mode == MODE_SUB);
      assign w_a   = a;
      assign w_b   = (mode == MODE_SUB) ? ~b : b;
      assign w_s   = '0;
    end else begin : g_body
      assign w_v   = g_stage[k-1].r_ctl.valid;
      assign w_cin = g_stage[k-1].r_ctl.carry;
      assign w_a   = g_stage[k-1].r_a;
      assign w_b   = g_stage[k-1].r_b;
      assign w_s   = g_stage[k-1].r_s;
    end
    rca_chunk #(.W(CW)) u_rca (
      .a      (w_a[CW-1:0]),
      .b      (w_b[CW-1:0]),
      .cin    (w_cin),
      .sum    (w_sum),
      .cout   (w_co),
      .msb_cin(w_cm)
    );
    // Operands shift down to expose the next chunk; sum chunks enter at the top and shift down
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_ctl <= '0;
        r_a   <= '0;
        r_b   <= '0;
        r_s   <= '0;
      end else if (w_en) begin
        r_ctl <= '{valid: w_v, carry: w_co, ovf: w_co ^ w_cm};
        r_a   <= w_a >> CW;
        r_b   <= w_b >> CW;
        r_s   <= (w_s >> CW) | (WIDTH'(w_sum) << (WIDTH - CW));
      end
    end
  end
  assign out_valid = g_stage[STAGES-1].r_ctl.valid;
  assign cout      = g_stage[STAGES-1].r_ctl.carry;
  assign ovf       = g_stage[STAGES-1].r_ctl.ovf;
  assign sum       = g_stage[STAGES-1].r_s;
endmodule

// File: tb/tb_pipe_addsub.sv
// tb_pipe_addsub: scoreboard bench for pipe_addsub at 16/4 and 32/8.
module tb_pipe_addsub;
  typedef struct packed {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
  } res_t;

  logic clk = 1'b0;
  logic rst;
  logic iv1, ir1, ov1, or1, m1, co1, of1;
  logic [15:0] a1, b1, s1;
  logic iv2, ir2, ov2, or2, m2, co2, of2;
  logic [31:0] a2, b2, s2;
  res_t q1[$];
  res_t q2[$];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_addsub #(.WIDTH(16), .STAGES(4)) dut1 (
    .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .a(a1), .b(b1), .mode(m1),
    .out_valid(ov1), .out_ready(or1), .sum(s1), .cout(co1), .ovf(of1)
  );
  pipe_addsub #(.WIDTH(32), .STAGES(8)) dut2 (
    .clk(clk), .rst(rst), .in_valid(iv2), .in_ready(ir2), .a(a2), .b(b2), .mode(m2),
    .out_valid(ov2), .out_ready(or2), .sum(s2), .cout(co2), .ovf(of2)
  );

  function automatic res_t ref_op(input int w, input logic [31:0] a, input logic [31:0] b, input logic m);
    logic [63:0] msk, bx, t;
    res_t r;
    msk    = (64'd1 << w) - 64'd1;
    bx     = (m ? ~{32'd0, b} : {32'd0, b}) & msk;
    t      = {32'd0, a} + bx + 64'(m);
    r.sum  = t[31:0] & msk[31:0];
    r.cout = t[w];
    r.ovf  = (a[w-1] == bx[w-1]) && (t[w-1] != a[w-1]);
    return r;
  endfunction

  task automatic step1(input logic v, input logic [15:0] a, input logic [15:0] b, input logic m,
                       input logic ordy, output logic ret, output res_t got, output logic acc);
    @(negedge clk);
    or1 = ordy;
    #1;
    ret = ov1 && or1;
    got = '{sum: {16'd0, s1}, cout: co1, ovf: of1};
    iv1 = v; a1 = a; b1 = b; m1 = m;
    acc = v && ir1;
    if (acc) q1.push_back(ref_op(16, {16'd0, a}, {16'd0, b}, m));
  endtask

  task automatic step2(input logic v, input logic [31:0] a, input logic [31:0] b, input logic m,
                       input logic ordy, output logic ret, output res_t got, output logic acc);
    @(negedge clk);
    or2 = ordy;
    #1;
    ret = ov2 && or2;
    got = '{sum: s2, cout: co2, ovf: of2};
    iv2 = v; a2 = a; b2 = b; m2 = m;
    acc = v && ir2;
    if (acc) q2.push_back(ref_op(32, a, b, m));
  endtask

  task automatic test_reset;
    #12;
    checks++;
    if (ov1 !== 1'b0 || ov2 !== 1'b0) begin
      errors++; $display("FAIL reset_valid got=%b/%b exp=0/0", ov1, ov2);
    end
    checks++;
    if (s1 !== 16'd0 || co1 !== 1'b0 || of1 !== 1'b0) begin
      errors++; $display("FAIL reset_outputs got=%h/%b/%b exp=0000/0/0", s1, co1, of1);
    end
    checks++;
    if (ir1 !== 1'b1 || ir2 !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready got=%b/%b exp=1/1", ir1, ir2);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_add;
    logic ret, acc;
    res_t got, exp;
    int n_ret = 0;
    step1(1'b1, 16'h1234, 16'h4321, 1'b0, 1'b1, ret, got, acc);
    checks++;
    if (!acc) begin errors++; $display("FAIL add_accept got=%b exp=1", acc); end
    for (int n = 1; n <= 8; n++) begin
      step1(1'b0, 16'h0, 16'h0, 1'b0, 1'b1, ret, got, acc);
      if (ret) begin
        n_ret++;
        checks++;
        if (n != 4) begin errors++; $display("FAIL add_latency got=%0d exp=4", n); end
        checks++;
        if (q1.size() == 0) begin errors++; $display("FAIL add_sb unexpected got=%h", got.sum); end
        else begin
          exp = q1.pop_front();
          if (got !== exp) begin errors++; $display("FAIL add_sb got=%h/%b/%b exp=%h/%b/%b", got.sum, got.cout, got.ovf, exp.sum, exp.cout, exp.ovf); end
        end
        checks++;
        if (got !== res_t'{32'h5555, 1'b0, 1'b0}) begin
          errors++; $display("FAIL add_value got=%h/%b/%b exp=5555/0/0", got.sum, got.cout, got.ovf);
        end
      end
    end
    checks++;
    if (n_ret != 1) begin errors++; $display("FAIL add_count got=%0d exp=1", n_ret); end
  endtask

  task automatic test_sub;
    logic [15:0] ta[2], tb[2];
    res_t te[2];
    logic ret, acc;
    res_t got, exp;
    int n_ret = 0;
    ta = '{16'h0005, 16'h0007};
    tb = '{16'h0007, 16'h0005};
    te = '{'{32'h0000FFFE, 1'b0, 1'b0}, '{32'h00000002, 1'b1, 1'b0}};
    for (int i = 0; i < 12; i++) begin
      if (i < 2) step1(1'b1, ta[i], tb[i], 1'b1, 1'b1, ret, got, acc);
      else step1(1'b0, 16'h0, 16'h0, 1'b0, 1'b1, ret, got, acc);
      if (ret) begin
        checks++;
        if (q1.size() == 0) begin errors++; $display("FAIL sub_sb unexpected got=%h", got.sum); end
        else begin
          exp = q1.pop_front();
          if (got !== exp) begin errors++; $display("FAIL sub_sb got=%h/%b/%b exp=%h/%b/%b", got.sum, got.cout, got.ovf, exp.sum, exp.cout, exp.ovf); end
        end
        if (n_ret < 2) begin
          checks++;
          if (got !== te[n_ret]) begin
            errors++; $display("FAIL sub_value%0d got=%h/%b/%b exp=%h/%b/%b", n_ret, got.sum, got.cout, got.ovf, te[n_ret].sum, te[n_ret].cout, te[n_ret].ovf);
          end
        end
        n_ret++;
      end
    end
    checks++;
    if (n_ret != 2) begin errors++; $display("FAIL sub_count got=%0d exp=2", n_ret); end
  endtask

  task automatic test_boundary;
    logic [15:0] ta[3], tb[3];
    logic tm[3];
    res_t te[3];
    logic ret, acc;
    res_t got, exp;
    int n_ret = 0;
    ta = '{16'h7FFF, 16'hFFFF, 16'h8000};
    tb = '{16'h0001, 16'h0001, 16'h0001};
    tm = '{1'b0, 1'b0, 1'b1};
    te = '{'{32'h00008000, 1'b0, 1'b1}, '{32'h00000000, 1'b1, 1'b0}, '{32'h00007FFF, 1'b1, 1'b1}};
    for (int i = 0; i < 12; i++) begin
      if (i < 3) step1(1'b1, ta[i], tb[i], tm[i], 1'b1, ret, got, acc);
      else step1(1'b0, 16'h0, 16'h0, 1'b0, 1'b1, ret, got, acc);
      if (ret) begin
        checks++;
        if (q1.size() == 0) begin errors++; $display("FAIL bnd_sb unexpected got=%h", got.sum); end
        else begin
          exp = q1.pop_front();
          if (got !== exp) begin errors++; $display("FAIL bnd_sb got=%h/%b/%b exp=%h/%b/%b", got.sum, got.cout, got.ovf, exp.sum, exp.cout, exp.ovf); end
        end
        if (n_ret < 3) begin
          checks++;
          if (got !== te[n_ret]) begin
            errors++; $display("FAIL bnd_value%0d got=%h/%b/%b exp=%h/%b/%b", n_ret, got.sum, got.cout, got.ovf, te[n_ret].sum, te[n_ret].cout, te[n_ret].ovf);
          end
        end
        n_ret++;
      end
    end
    checks++;
    if (n_ret != 3) begin errors++; $display("FAIL bnd_count got=%0d exp=3", n_ret); end
  endtask

  task automatic test_back_to_back;
    logic ret, acc, st;
    res_t got, exp, hold;
    int idx = 0;
    int n_ret = 0;
    hold = '0;
    for (int c = 0; c < 60 && n_ret < 8; c++) begin
      st = (c >= 6 && c <= 8);
      step1(idx < 8, 16'(idx * 16'h1111), 16'(16'h0F0F + idx), idx[0], !st, ret, got, acc);
      if (acc) idx++;
      if (st) begin
        checks++;
        if (ir1 !== 1'b0 || ov1 !== 1'b1) begin
          errors++; $display("FAIL stall_ready got=in_ready %b out_valid %b exp=0/1", ir1, ov1);
        end
        if (c == 6) hold = got;
        else begin
          checks++;
          if (got !== hold) begin errors++; $display("FAIL stall_hold got=%h/%b/%b exp=%h/%b/%b", got.sum, got.cout, got.ovf, hold.sum, hold.cout, hold.ovf); end
        end
      end
      if (ret) begin
        n_ret++;
        checks++;
        if (q1.size() == 0) begin errors++; $display("FAIL b2b_sb unexpected got=%h", got.sum); end
        else begin
          exp = q1.pop_front();
          if (got !== exp) begin errors++; $display("FAIL b2b_sb got=%h/%b/%b exp=%h/%b/%b", got.sum, got.cout, got.ovf, exp.sum, exp.cout, exp.ovf); end
        end
      end
    end
    checks++;
    if (n_ret != 8 || q1.size() != 0) begin errors++; $display("FAIL b2b_count got=%0d exp=8", n_ret); end
  endtask

  task automatic test_reset_flight;
    logic ret, acc;
    res_t got, exp;
    int n_ret = 0;
    for (int i = 0; i < 3; i++) step1(1'b1, 16'(16'h0101 * (i + 1)), 16'h0202, 1'b0, 1'b1, ret, got, acc);
    step1(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, ret, got, acc);
    step1(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, ret, got, acc);
    checks++;
    if (ov1 !== 1'b1) begin errors++; $display("FAIL flight_prestate got=%b exp=1", ov1); end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (ov1 !== 1'b0 || s1 !== 16'd0) begin errors++; $display("FAIL flight_async got=%b/%h exp=0/0000", ov1, s1); end
    q1.delete();
    @(negedge clk);
    rst = 1'b0;
    step1(1'b1, 16'h0100, 16'h0023, 1'b0, 1'b1, ret, got, acc);
    for (int n = 1; n <= 10; n++) begin
      step1(1'b0, 16'h0, 16'h0, 1'b0, 1'b1, ret, got, acc);
      if (ret) begin
        n_ret++;
        checks++;
        if (n != 4) begin errors++; $display("FAIL flight_latency got=%0d exp=4", n); end
        checks++;
        if (q1.size() == 0) begin errors++; $display("FAIL flight_sb unexpected got=%h", got.sum); end
        else begin
          exp = q1.pop_front();
          if (got !== exp || got.sum !== 32'h0123) begin errors++; $display("FAIL flight_sb got=%h/%b/%b exp=00000123/0/0", got.sum, got.cout, got.ovf); end
        end
      end
    end
    checks++;
    if (n_ret != 1) begin errors++; $display("FAIL flight_count got=%0d exp=1", n_ret); end
  endtask

  task automatic test_random16;
    logic ret, acc;
    res_t got, exp;
    int n_acc = 0;
    int shown = 0;
    for (int c = 0; c < 40000 && (n_acc < 10000 || q1.size() != 0); c++) begin
      step1(n_acc < 10000 && $urandom_range(0, 9) < 9, 16'($urandom), 16'($urandom),
            1'($urandom_range(0, 1)), n_acc >= 10000 || $urandom_range(0, 4) != 0, ret, got, acc);
      if (acc) n_acc++;
      if (ret) begin
        checks++;
        exp = (q1.size() != 0) ? q1.pop_front() : 'x;
        if (got !== exp) begin
          errors++;
          if (shown++ < 10) $display("FAIL rand16 got=%h/%b/%b exp=%h/%b/%b", got.sum, got.cout, got.ovf, exp.sum, exp.cout, exp.ovf);
        end
      end
    end
    checks++;
    if (n_acc != 10000 || q1.size() != 0) begin errors++; $display("FAIL rand16_drain got=%0d/%0d exp=10000/0", n_acc, q1.size()); end
  endtask

  task automatic test_random32;
    logic ret, acc;
    res_t got, exp;
    int n_acc = 0;
    int shown = 0;
    for (int c = 0; c < 40000 && (n_acc < 10000 || q2.size() != 0); c++) begin
      step2(n_acc < 10000 && $urandom_range(0, 9) < 9, $urandom, $urandom,
            1'($urandom_range(0, 1)), n_acc >= 10000 || $urandom_range(0, 4) != 0, ret, got, acc);
      if (acc) n_acc++;
      if (ret) begin
        checks++;
        exp = (q2.size() != 0) ? q2.pop_front() : 'x;
        if (got !== exp) begin
          errors++;
          if (shown++ < 10) $display("FAIL rand32 got=%h/%b/%b exp=%h/%b/%b", got.sum, got.cout, got.ovf, exp.sum, exp.cout, exp.ovf);
        end
      end
    end
    checks++;
    if (n_acc != 10000 || q2.size() != 0) begin errors++; $display("FAIL rand32_drain got=%0d/%0d exp=10000/0", n_acc, q2.size()); end
  endtask

  initial begin
    rst = 1'b1;
    iv1 = 1'b0; or1 = 1'b0; a1 = '0; b1 = '0; m1 = 1'b0;
    iv2 = 1'b0; or2 = 1'b0; a2 = '0; b2 = '0; m2 = 1'b0;
    test_reset;
    test_add;
    test_sub;
    test_boundary;
    test_back_to_back;
    test_reset_flight;
    test_random16;
    test_random32;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
